rr_mux_scheduler: RTL

Round-robin scheduler and output register that drives the select of the 4:1 nibble multiplexer and consumes its output. Four producer channels each present 4-bit data with valid/ready. The block grants one channel at a time for a burst of up to `BURST_MAX` beats and drives `sel` to the multiplexer. It captures the selected nibble into a registered valid/ready output stage tagged with its channel number.

---
 rtl/rr_mux_scheduler_pkg.sv | 15 +
 rtl/nibble_mux4.sv | 22 ++
 rtl/rr_mux_scheduler_pick4.sv | 31 +++
 rtl/rr_mux_scheduler.sv | 98 +++++++++
 4 files changed

// File: rtl/rr_mux_scheduler_pkg.sv
// Shared types and constants for the round-robin nibble scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_mux_scheduler_pkg;

  localparam int CH_NUM     = 4;  // producer channels
  localparam int CH_W       = 2;  // channel index width
  localparam int DATA_W_DEF = 4;  // default per-channel data width

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } sched_state_t;

endpackage

// File: rtl/nibble_mux4.sv
// 4:1 data multiplexer; channel n sits at data[n*W +: W].
// Latency: combinational.
// Backpressure: none.
// Ports: data (4 packed lanes), sel (lane index), y (selected lane).
module nibble_mux4 #(
  parameter int W = 4
) (
  input  logic [4*W-1:0] data,
  input  logic [1:0]     sel,
  output logic [W-1:0]   y
);

  always_comb begin
    case (sel)
      2'd0:    y = data[0*W +: W];
      2'd1:    y = data[1*W +: W];
      2'd2:    y = data[2*W +: W];
      default: y = data[3*W +: W];
    endcase
  end

endmodule

// File: rtl/rr_mux_scheduler_pick4.sv
// Round-robin pick among 4 requesters, scanning last+1 .. last+4 (mod 4).
// Latency: combinational.
// Backpressure: none; grant equals last when nothing requests.
// Ports: req (request vector), last (previous grant), grant (winner), any (some request set).
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  // The previous winner is scanned last, so it only wins again when alone.
  always_comb begin
    grant = last;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin burst scheduler driving a 4:1 nibble mux, with a registered tagged output stage.
// Latency: in_valid in cycle T -> grant at T edge, in_ready in T+1, out_valid in T+2; 1 beat/cycle in a burst.
// Backpressure: in_ready of the granted channel drops while the output register is full and out_ready is low.
// Ports: clk/rst (sync, active high); in_valid/in_data/in_ready per channel; sel to mux;
//        out_valid/out_ready/out_data/out_ch output stage; busy while a burst is granted.
module rr_mux_scheduler
  import rr_mux_scheduler_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        in_valid,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic [CH_NUM-1:0]        in_ready,
  output logic [CH_W-1:0]          sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

  sched_state_t      state;
  logic [3:0]        burst_cnt;
  logic [CH_W-1:0]   pick;
  logic              any_req;
  logic [DATA_W-1:0] mux_y;
  logic              out_free;
  logic              accept;

  rr_pick4 u_pick (
    .req   (in_valid),
    .last  (sel),
    .grant (pick),
    .any   (any_req)
  );

  // sel is held for the whole burst, so the mux output is stable when captured.
  nibble_mux4 #(.W(DATA_W)) u_mux (
    .data (in_data),
    .sel  (sel),
    .y    (mux_y)
  );

  // The output register can take a beat if empty or draining this cycle.
  assign out_free = !out_valid || out_ready;
  assign accept   = (state == S_XFER) && in_valid[sel] && out_free;
  assign busy     = (state == S_XFER);

  always_comb begin
    in_ready = '0;
    if (state == S_XFER) in_ready[sel] = out_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= 2'b11;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel       <= pick;
            burst_cnt <= '0;
            state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 4'd1;
            if (burst_cnt == LAST_BEAT) state <= S_IDLE;
          end else if (!in_valid[sel]) begin
            // Granted producer went quiet: give the others a turn.
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        out_data  <= mux_y;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
